// File: rtl/rng_dac_scheduler.sv
// rng_dac_scheduler: shares one serial DAC between the periodic RNG sample
// path and host writes. A tick counter raises a pending sample request, an
// IDLE-state arbiter grants RNG or host (round-robin on contention), and the
// granted word is shifted MSB-first on dac_sclk/dac_din framed by dac_sync_n.
module rng_dac_scheduler #(
   parameter int DATA_W         = 14,
   parameter int SCLK_DIV       = 4,
   parameter int DEFAULT_PERIOD = 250000
) (
   input  logic              qzt_clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [29:0]       period,
   input  logic              hold,
   input  logic              rng_valid,
   input  logic [DATA_W-1:0] rng_data,
   output logic              rng_ack,
   input  logic              host_req,
   input  logic [DATA_W-1:0] host_data,
   output logic              host_ack,
   output logic              dac_sclk,
   output logic              dac_din,
   output logic              dac_sync_n,
   output logic              busy,
   output logic              last_src,
   output logic [DATA_W-1:0] dac_word,
   output logic              overrun
);

   localparam int PH_W  = $clog2(2 * SCLK_DIV);
   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [PH_W-1:0]  PH_HI   = PH_W'(SCLK_DIV - 1);
   localparam logic [PH_W-1:0]  PH_END  = PH_W'(2 * SCLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_END = BIT_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, GRANT, SHIFT, DONE} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [29:0]        cnt;
   logic [29:0]        per;
   logic               tick;
   logic               pending;
   logic               rng_el;
   logic               host_el;
   logic               grant_go;
   logic               grant_host;
   logic               rng_clr;
   logic [PH_W-1:0]    ph;
   logic [BIT_W-1:0]   bit_idx;
   logic [DATA_W-1:0]  sreg;
   logic [DATA_W-1:0]  word;

   assign busy = (state != IDLE);

   // Effective tick period and tick strobe; >= so a lowered period fires at once.
   always_comb begin
      per  = (period == 30'd0) ? 30'(DEFAULT_PERIOD) : period;
      tick = enable && (cnt >= (per - 30'd1));
   end

   // Arbitration in IDLE and next-state logic for the frame sequencer.
   always_comb begin
      state_nxt  = state;
      rng_el     = 1'b0;
      host_el    = 1'b0;
      grant_go   = 1'b0;
      grant_host = 1'b0;
      case (state)
         IDLE: begin
            rng_el     = pending & rng_valid & ~hold;
            host_el    = host_req & ~hold;
            grant_go   = rng_el | host_el;
            // On contention the source that did not win last time gets the grant.
            grant_host = host_el & (~rng_el | ~last_src);
            if (grant_go) state_nxt = GRANT;
         end
         GRANT:   state_nxt = SHIFT;
         SHIFT:   if (ph == PH_END && bit_idx == BIT_END) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      rng_clr = grant_go & ~grant_host;
   end

   // State register.
   always_ff @(posedge qzt_clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Sample-period counter: held at zero while disabled, keeps running while busy.
   always_ff @(posedge qzt_clk) begin
      if (reset)                cnt <= 30'd0;
      else if (!enable || tick) cnt <= 30'd0;
      else                      cnt <= cnt + 30'd1;
   end

   // Pending sample flag and sticky overrun; a tick coinciding with an RNG grant
   // re-arms pending without counting as an overrun.
   always_ff @(posedge qzt_clk) begin
      if (reset) begin
         pending <= 1'b0;
         overrun <= 1'b0;
      end else if (tick) begin
         pending <= 1'b1;
         if (pending && !rng_clr) overrun <= 1'b1;
      end else if (rng_clr) begin
         pending <= 1'b0;
      end
   end

   // Word capture, acks and serial shifter (low phase then high phase per bit).
   always_ff @(posedge qzt_clk) begin
      if (reset) begin
         rng_ack    <= 1'b0;
         host_ack   <= 1'b0;
         dac_sclk   <= 1'b0;
         dac_din    <= 1'b0;
         dac_sync_n <= 1'b1;
         last_src   <= 1'b1;
         dac_word   <= '0;
         sreg       <= '0;
         word       <= '0;
         ph         <= '0;
         bit_idx    <= '0;
      end else begin
         rng_ack  <= grant_go & ~grant_host;
         host_ack <= grant_go & grant_host;
         case (state)
            IDLE: begin
               if (grant_go) begin
                  sreg     <= grant_host ? host_data : rng_data;
                  word     <= grant_host ? host_data : rng_data;
                  last_src <= grant_host;
               end
            end
            GRANT: begin
               dac_sync_n <= 1'b0;
               dac_sclk   <= 1'b0;
               dac_din    <= sreg[DATA_W-1];
               ph         <= '0;
               bit_idx    <= '0;
            end
            SHIFT: begin
               ph <= ph + PH_W'(1);
               if (ph == PH_HI) dac_sclk <= 1'b1;
               if (ph == PH_END) begin
                  ph       <= '0;
                  dac_sclk <= 1'b0;
                  if (bit_idx == BIT_END) begin
                     dac_sync_n <= 1'b1;
                     dac_din    <= 1'b0;
                     dac_word   <= word;
                  end else begin
                     sreg    <= {sreg[DATA_W-2:0], 1'b0};
                     dac_din <= sreg[DATA_W-2];
                     bit_idx <= bit_idx + BIT_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
